// File: rtl/wb_sel_stage_pkg.sv
// Shared encodings for the writeback select stage: source selects, load sizes
// and the skid-buffer occupancy state.
package wb_sel_stage_pkg;

    typedef enum logic [2:0] {
        SEL_ALU    = 3'b000,
        SEL_LU     = 3'b001,
        SEL_IMM    = 3'b010,
        SEL_IADDER = 3'b011,
        SEL_CSR    = 3'b100,
        SEL_PC4    = 3'b101,
        SEL_RSV6   = 3'b110,
        SEL_RSV7   = 3'b111
    } wb_sel_e;

    typedef enum logic [1:0] {
        LD_BYTE = 2'b00,
        LD_HALF = 2'b01,
        LD_WORD = 2'b10
    } load_size_e;

    typedef enum logic [1:0] {
        SKID_EMPTY = 2'b00,
        SKID_ONE   = 2'b01,
        SKID_FULL  = 2'b10
    } skid_state_e;

    // Selects 110 and 111 carry no writeback source.
    function automatic logic is_reserved_sel(input logic [2:0] sel);
        return sel[2] & sel[1];
    endfunction

endpackage

// File: rtl/wb_load_ext.sv
// Load-unit result formatter: narrows to byte/half and sign- or zero-extends.
// Only instantiated when WB_LOAD_ALIGN_EN is defined.
module wb_load_ext
    import wb_sel_stage_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] data_i,
    input  logic [1:0]      size_i,
    input  logic            unsigned_i,
    output logic [XLEN-1:0] data_o
);

    logic byte_fill;
    logic half_fill;

    assign byte_fill = ~unsigned_i & data_i[7];
    assign half_fill = ~unsigned_i & data_i[15];

    // NOTE: data_o gets a default before the case so no path leaves it unassigned (no latch).
    always_comb begin
        data_o = data_i;
        case (size_i)
            LD_BYTE: data_o = {{(XLEN-8){byte_fill}}, data_i[7:0]};
            LD_HALF: data_o = {{(XLEN-16){half_fill}}, data_i[15:0]};
            default: data_o = data_i;
        endcase
    end

endmodule

// File: rtl/wb_sel_stage.sv
// Writeback source select feeding a 2-entry skid buffer toward the register file.
// Optional macro WB_LOAD_ALIGN_EN enables byte/half load extension on the LU source.
module wb_sel_stage
    import wb_sel_stage_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int RD_W = 5
) (
    input  logic            clk_in,
    input  logic            rst_n_in,
    input  logic            flush_in,
    input  logic            valid_in,
    output logic            ready_out,
    input  logic [2:0]      wb_mux_sel_in,
    input  logic [RD_W-1:0] rd_addr_in,
    input  logic            rf_wr_en_in,
    input  logic [XLEN-1:0] alu_result_in,
    input  logic [XLEN-1:0] lu_output_in,
    input  logic [XLEN-1:0] imm_in,
    input  logic [XLEN-1:0] iadder_out_in,
    input  logic [XLEN-1:0] csr_data_in,
    input  logic [XLEN-1:0] pc_plus_4_in,
    input  logic [1:0]      load_size_in,
    input  logic            load_unsigned_in,
    output logic            valid_out,
    input  logic            ready_in,
    output logic [XLEN-1:0] wb_data_out,
    output logic [RD_W-1:0] rd_addr_out,
    output logic            rf_wr_en_out,
    output logic            sel_err_out
);

    skid_state_e     state_q, state_d;
    logic [XLEN-1:0] head_data_q, head_data_d;
    logic [RD_W-1:0] head_rd_q, head_rd_d;
    logic            head_we_q, head_we_d;
    logic [XLEN-1:0] tail_data_q, tail_data_d;
    logic [RD_W-1:0] tail_rd_q, tail_rd_d;
    logic            tail_we_q, tail_we_d;
    logic            sel_err_q, sel_err_d;

    logic [XLEN-1:0] lu_data;
    logic [XLEN-1:0] sel_data;
    logic            sel_we;
    logic            sel_rsv;
    logic            accept;
    logic            drain;

`ifdef WB_LOAD_ALIGN_EN
    wb_load_ext #(
        .XLEN(XLEN)
    ) u_load_ext (
        .data_i     (lu_output_in),
        .size_i     (load_size_in),
        .unsigned_i (load_unsigned_in),
        .data_o     (lu_data)
    );
`else
    logic unused_load_fmt;
    assign unused_load_fmt = ^{load_size_in, load_unsigned_in};
    assign lu_data         = lu_output_in;
`endif

    // ready_out depends only on occupancy, never on ready_in.
    assign ready_out = (state_q != SKID_FULL);
    assign valid_out = (state_q != SKID_EMPTY);
    assign accept    = valid_in & ready_out;
    assign drain     = valid_out & ready_in;

    assign sel_rsv = is_reserved_sel(wb_mux_sel_in);
    assign sel_we  = rf_wr_en_in & (rd_addr_in != '0) & ~sel_rsv;

    always_comb begin
        sel_data = '0;
        case (wb_mux_sel_in)
            SEL_ALU:    sel_data = alu_result_in;
            SEL_LU:     sel_data = lu_data;
            SEL_IMM:    sel_data = imm_in;
            SEL_IADDER: sel_data = iadder_out_in;
            SEL_CSR:    sel_data = csr_data_in;
            SEL_PC4:    sel_data = pc_plus_4_in;
            default:    sel_data = '0;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        head_data_d = head_data_q;
        head_rd_d   = head_rd_q;
        head_we_d   = head_we_q;
        tail_data_d = tail_data_q;
        tail_rd_d   = tail_rd_q;
        tail_we_d   = tail_we_q;
        sel_err_d   = 1'b0;

        if (flush_in) begin
            state_d = SKID_EMPTY;
        end else begin
            sel_err_d = accept & sel_rsv;
            case (state_q)
                SKID_EMPTY: begin
                    if (accept) begin
                        head_data_d = sel_data;
                        head_rd_d   = rd_addr_in;
                        head_we_d   = sel_we;
                        state_d     = SKID_ONE;
                    end
                end
                SKID_ONE: begin
                    if (accept && drain) begin
                        head_data_d = sel_data;
                        head_rd_d   = rd_addr_in;
                        head_we_d   = sel_we;
                    end else if (accept) begin
                        tail_data_d = sel_data;
                        tail_rd_d   = rd_addr_in;
                        tail_we_d   = sel_we;
                        state_d     = SKID_FULL;
                    end else if (drain) begin
                        state_d = SKID_EMPTY;
                    end
                end
                SKID_FULL: begin
                    // Tail is the older-but-one entry; it moves up so order is kept.
                    if (drain) begin
                        head_data_d = tail_data_q;
                        head_rd_d   = tail_rd_q;
                        head_we_d   = tail_we_q;
                        state_d     = SKID_ONE;
                    end
                end
                default: state_d = SKID_EMPTY;
            endcase
        end
    end

    // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
    // NOTE: entry payloads are reset too, because wb_data_out/rd_addr_out must read zero in reset.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q     <= SKID_EMPTY;
            head_data_q <= '0;
            head_rd_q   <= '0;
            head_we_q   <= 1'b0;
            tail_data_q <= '0;
            tail_rd_q   <= '0;
            tail_we_q   <= 1'b0;
            sel_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            head_data_q <= head_data_d;
            head_rd_q   <= head_rd_d;
            head_we_q   <= head_we_d;
            tail_data_q <= tail_data_d;
            tail_rd_q   <= tail_rd_d;
            tail_we_q   <= tail_we_d;
            sel_err_q   <= sel_err_d;
        end
    end

    assign wb_data_out  = head_data_q;
    assign rd_addr_out  = head_rd_q;
    assign rf_wr_en_out = head_we_q & valid_out;
    assign sel_err_out  = sel_err_q;

endmodule

// File: tb/tb_wb_sel_stage.sv
// Self-checking bench for wb_sel_stage: directed scenario tasks plus a
// negedge scoreboard that predicts every accepted entry and its drain order.
module tb_wb_sel_stage;
    import wb_sel_stage_pkg::*;

    localparam int XLEN = 32;
    localparam int RD_W = 5;

    logic            clk_in = 1'b0;
    logic            rst_n_in;
    logic            flush_in;
    logic            valid_in;
    logic            ready_out;
    logic [2:0]      wb_mux_sel_in;
    logic [RD_W-1:0] rd_addr_in;
    logic            rf_wr_en_in;
    logic [XLEN-1:0] alu_result_in;
    logic [XLEN-1:0] lu_output_in;
    logic [XLEN-1:0] imm_in;
    logic [XLEN-1:0] iadder_out_in;
    logic [XLEN-1:0] csr_data_in;
    logic [XLEN-1:0] pc_plus_4_in;
    logic [1:0]      load_size_in;
    logic            load_unsigned_in;
    logic            valid_out;
    logic            ready_in;
    logic [XLEN-1:0] wb_data_out;
    logic [RD_W-1:0] rd_addr_out;
    logic            rf_wr_en_out;
    logic            sel_err_out;

    typedef struct {
        logic [XLEN-1:0] data;
        logic [RD_W-1:0] rd;
        logic            we;
    } exp_t;

    exp_t sb_q[$];
    logic err_exp = 1'b0;
    bit   mon_en  = 1'b0;
    int   errors  = 0;
    int   checks  = 0;

    always #5 clk_in = ~clk_in;

    wb_sel_stage #(
        .XLEN(XLEN),
        .RD_W(RD_W)
    ) dut (
        .clk_in           (clk_in),
        .rst_n_in         (rst_n_in),
        .flush_in         (flush_in),
        .valid_in         (valid_in),
        .ready_out        (ready_out),
        .wb_mux_sel_in    (wb_mux_sel_in),
        .rd_addr_in       (rd_addr_in),
        .rf_wr_en_in      (rf_wr_en_in),
        .alu_result_in    (alu_result_in),
        .lu_output_in     (lu_output_in),
        .imm_in           (imm_in),
        .iadder_out_in    (iadder_out_in),
        .csr_data_in      (csr_data_in),
        .pc_plus_4_in     (pc_plus_4_in),
        .load_size_in     (load_size_in),
        .load_unsigned_in (load_unsigned_in),
        .valid_out        (valid_out),
        .ready_in         (ready_in),
        .wb_data_out      (wb_data_out),
        .rd_addr_out      (rd_addr_out),
        .rf_wr_en_out     (rf_wr_en_out),
        .sel_err_out      (sel_err_out)
    );

    function automatic logic [XLEN-1:0] model_lu();
`ifdef WB_LOAD_ALIGN_EN
        case (load_size_in)
            2'b00:   return load_unsigned_in ? {24'h0, lu_output_in[7:0]}
                                             : {{24{lu_output_in[7]}}, lu_output_in[7:0]};
            2'b01:   return load_unsigned_in ? {16'h0, lu_output_in[15:0]}
                                             : {{16{lu_output_in[15]}}, lu_output_in[15:0]};
            default: return lu_output_in;
        endcase
`else
        return lu_output_in;
`endif
    endfunction

    function automatic exp_t model_entry();
        exp_t e;
        case (wb_mux_sel_in)
            3'd0:    e.data = alu_result_in;
            3'd1:    e.data = model_lu();
            3'd2:    e.data = imm_in;
            3'd3:    e.data = iadder_out_in;
            3'd4:    e.data = csr_data_in;
            3'd5:    e.data = pc_plus_4_in;
            default: e.data = '0;
        endcase
        e.rd = rd_addr_in;
        e.we = rf_wr_en_in && (rd_addr_in != 0) && (wb_mux_sel_in < 3'd6);
        return e;
    endfunction

    // Scoreboard: checks outputs against the model, then predicts the coming edge.
    always @(negedge clk_in) begin
        if (rst_n_in && mon_en) begin
            int   n;
            logic m_valid;
            logic m_ready;
            n       = sb_q.size();
            m_valid = (n != 0);
            m_ready = (n < 2);
            checks++;
            if (valid_out !== m_valid) begin
                errors++;
                $display("FAIL sb_valid t=%0t got %b want %b", $time, valid_out, m_valid);
            end
            checks++;
            if (ready_out !== m_ready) begin
                errors++;
                $display("FAIL sb_ready t=%0t got %b want %b", $time, ready_out, m_ready);
            end
            checks++;
            if (sel_err_out !== err_exp) begin
                errors++;
                $display("FAIL sb_sel_err t=%0t got %b want %b", $time, sel_err_out, err_exp);
            end
            if (m_valid) begin
                checks++;
                if (wb_data_out !== sb_q[0].data || rd_addr_out !== sb_q[0].rd
                    || rf_wr_en_out !== sb_q[0].we) begin
                    errors++;
                    $display("FAIL sb_entry t=%0t got %h/%0d/%b want %h/%0d/%b", $time,
                             wb_data_out, rd_addr_out, rf_wr_en_out,
                             sb_q[0].data, sb_q[0].rd, sb_q[0].we);
                end
            end
            err_exp = 1'b0;
            if (flush_in) begin
                sb_q.delete();
            end else begin
                if (m_valid && ready_in) void'(sb_q.pop_front());
                if (valid_in && m_ready) begin
                    sb_q.push_back(model_entry());
                    err_exp = (wb_mux_sel_in >= 3'd6);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic drive(input logic v, input logic [2:0] sel, input logic [RD_W-1:0] rd,
                         input logic we);
        valid_in      = v;
        wb_mux_sel_in = sel;
        rd_addr_in    = rd;
        rf_wr_en_in   = we;
    endtask

    task automatic test_reset();
        rst_n_in = 1'b0;
        flush_in = 1'b0;
        ready_in = 1'b0;
        drive(1'b1, 3'd0, 5'd1, 1'b1);
        alu_result_in = 32'h1111_1111; lu_output_in = 32'h2222_2222; imm_in = 32'h3333_3333;
        iadder_out_in = 32'h4444_4444; csr_data_in = 32'h5555_5555; pc_plus_4_in = 32'h6666_6666;
        load_size_in = 2'b10; load_unsigned_in = 1'b0;
        repeat (3) @(posedge clk_in);
        #2;
        checks++;
        if ({valid_out, rf_wr_en_out, sel_err_out, wb_data_out, rd_addr_out} !== '0) begin
            errors++;
            $display("FAIL reset_outputs got v=%b we=%b err=%b d=%h rd=%0d want all 0",
                     valid_out, rf_wr_en_out, sel_err_out, wb_data_out, rd_addr_out);
        end
        checks++;
        if (ready_out !== 1'b1) begin
            errors++;
            $display("FAIL reset_ready got %b want 1", ready_out);
        end
        valid_in = 1'b0;
        rst_n_in = 1'b1;
        sb_q.delete();
        err_exp = 1'b0;
        mon_en  = 1'b1;
        tick();
    endtask

    task automatic test_sources();
        ready_in = 1'b1;
        for (int s = 0; s < 8; s++) begin
            logic [XLEN-1:0] want;
            drive(1'b1, 3'(s), 5'(s + 1), 1'b1);
            want = model_entry().data;
            tick();
            checks++;
            if (wb_data_out !== want || valid_out !== 1'b1) begin
                errors++;
                $display("FAIL source_sel%0d got %h v=%b want %h v=1", s, wb_data_out, valid_out, want);
            end
        end
        valid_in = 1'b0;
        tick();
    endtask

    task automatic test_load_ext();
        logic [XLEN-1:0] want;
        logic [XLEN-1:0] lu_vals[4] = '{32'h0000_80F1, 32'h1234_7F80, 32'hFFFF_8001, 32'h8765_4321};
        ready_in = 1'b1;
        lu_output_in = 32'h0000_00F0; load_size_in = 2'b00; load_unsigned_in = 1'b0;
        drive(1'b1, 3'd1, 5'd4, 1'b1);
`ifdef WB_LOAD_ALIGN_EN
        want = 32'hFFFF_FFF0;
`else
        want = 32'h0000_00F0;
`endif
        tick();
        checks++;
        if (wb_data_out !== want) begin
            errors++;
            $display("FAIL load_byte_signed got %h want %h", wb_data_out, want);
        end
        for (int i = 0; i < 4; i++) begin
            for (int sz = 0; sz < 3; sz++) begin
                lu_output_in     = lu_vals[i];
                load_size_in     = 2'(sz);
                load_unsigned_in = 1'(i & 1);
                tick();
            end
        end
        valid_in = 1'b0;
        load_size_in = 2'b10;
        tick();
    endtask

    task automatic test_backpressure();
        ready_in = 1'b0;
        imm_in   = 32'h2;
        drive(1'b1, 3'd2, 5'd5, 1'b1);
        tick();
        imm_in = 32'h3;
        checks++;
        if (wb_data_out !== 32'h2 || ready_out !== 1'b1 || rd_addr_out !== 5'd5) begin
            errors++;
            $display("FAIL bp_first got d=%h rdy=%b rd=%0d want 2/1/5", wb_data_out, ready_out, rd_addr_out);
        end
        tick();
        imm_in = 32'h4;
        checks++;
        if (wb_data_out !== 32'h2 || ready_out !== 1'b0) begin
            errors++;
            $display("FAIL bp_full got d=%h rdy=%b want 2/0", wb_data_out, ready_out);
        end
        tick();
        checks++;
        if (wb_data_out !== 32'h2 || ready_out !== 1'b0 || valid_out !== 1'b1) begin
            errors++;
            $display("FAIL bp_hold got d=%h rdy=%b v=%b want 2/0/1", wb_data_out, ready_out, valid_out);
        end
        valid_in = 1'b0;
        ready_in = 1'b1;
        tick();
        checks++;
        if (wb_data_out !== 32'h3 || ready_out !== 1'b1) begin
            errors++;
            $display("FAIL bp_drain_order got d=%h rdy=%b want 3/1", wb_data_out, ready_out);
        end
        tick();
    endtask

    task automatic test_rd_zero();
        ready_in      = 1'b1;
        alu_result_in = 32'hA5A5_A5A5;
        drive(1'b1, 3'd0, 5'd0, 1'b1);
        tick();
        checks++;
        if (rf_wr_en_out !== 1'b0 || wb_data_out !== 32'hA5A5_A5A5) begin
            errors++;
            $display("FAIL rd_zero got we=%b d=%h want 0/a5a5a5a5", rf_wr_en_out, wb_data_out);
        end
        drive(1'b1, 3'd0, 5'd7, 1'b1);
        tick();
        checks++;
        if (rf_wr_en_out !== 1'b1) begin
            errors++;
            $display("FAIL rd_nonzero got we=%b want 1", rf_wr_en_out);
        end
        valid_in = 1'b0;
        tick();
    endtask

    task automatic test_reserved();
        ready_in = 1'b1;
        drive(1'b1, 3'd7, 5'd3, 1'b1);
        tick();
        checks++;
        if (wb_data_out !== '0 || rf_wr_en_out !== 1'b0 || sel_err_out !== 1'b1) begin
            errors++;
            $display("FAIL reserved got d=%h we=%b err=%b want 0/0/1", wb_data_out, rf_wr_en_out, sel_err_out);
        end
        valid_in = 1'b0;
        tick();
        checks++;
        if (sel_err_out !== 1'b0) begin
            errors++;
            $display("FAIL reserved_pulse got err=%b want 0", sel_err_out);
        end
    endtask

    task automatic test_flush();
        ready_in = 1'b0;
        drive(1'b1, 3'd4, 5'd6, 1'b1);
        repeat (2) tick();
        drive(1'b1, 3'd6, 5'd6, 1'b1);
        flush_in = 1'b1;
        tick();
        flush_in = 1'b0;
        valid_in = 1'b0;
        checks++;
        if (valid_out !== 1'b0 || ready_out !== 1'b1 || sel_err_out !== 1'b0) begin
            errors++;
            $display("FAIL flush got v=%b rdy=%b err=%b want 0/1/0", valid_out, ready_out, sel_err_out);
        end
        ready_in = 1'b1;
        tick();
    endtask

    task automatic test_async_reset();
        ready_in = 1'b0;
        imm_in   = 32'h55;
        drive(1'b1, 3'd2, 5'd8, 1'b1);
        tick();
        imm_in = 32'h66;
        tick();
        imm_in = 32'h77;
        #2;
        rst_n_in = 1'b0;
        #1;
        checks++;
        if ({valid_out, rf_wr_en_out, sel_err_out, wb_data_out, rd_addr_out} !== '0) begin
            errors++;
            $display("FAIL async_reset got v=%b we=%b err=%b d=%h rd=%0d want all 0",
                     valid_out, rf_wr_en_out, sel_err_out, wb_data_out, rd_addr_out);
        end
        sb_q.delete();
        err_exp  = 1'b0;
        valid_in = 1'b0;
        @(posedge clk_in);
        #3;
        rst_n_in = 1'b1;
        tick();
        ready_in = 1'b1;
        imm_in   = 32'h88;
        drive(1'b1, 3'd2, 5'd9, 1'b1);
        tick();
        checks++;
        if (wb_data_out !== 32'h88 || valid_out !== 1'b1 || ready_out !== 1'b1 || rd_addr_out !== 5'd9) begin
            errors++;
            $display("FAIL post_reset got d=%h v=%b rdy=%b rd=%0d want 88/1/1/9",
                     wb_data_out, valid_out, ready_out, rd_addr_out);
        end
        valid_in = 1'b0;
        tick();
    endtask

    task automatic test_back_to_back();
        bit drained;
        for (int c = 0; c < 300; c++) begin
            alu_result_in    = $urandom;
            lu_output_in     = $urandom;
            imm_in           = $urandom;
            iadder_out_in    = $urandom;
            csr_data_in      = $urandom;
            pc_plus_4_in     = $urandom;
            load_size_in     = 2'($urandom_range(0, 3));
            load_unsigned_in = 1'($urandom_range(0, 1));
            drive(1'($urandom_range(0, 3) != 0), 3'($urandom_range(0, 7)),
                  5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)));
            ready_in = 1'($urandom_range(0, 2) != 0);
            flush_in = ($urandom_range(0, 24) == 0);
            tick();
        end
        flush_in = 1'b0;
        valid_in = 1'b0;
        ready_in = 1'b1;
        drained  = 1'b0;
        for (int c = 0; c < 10 && !drained; c++) begin
            tick();
            drained = (sb_q.size() == 0) && (valid_out == 1'b0);
        end
        checks++;
        if (!drained) begin
            errors++;
            $display("FAIL drain_timeout got entries=%0d v=%b want 0/0", sb_q.size(), valid_out);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog got no finish want finish before 1ms");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_sources();
        test_load_ext();
        test_backpressure();
        test_rd_zero();
        test_reserved();
        test_flush();
        test_async_reset();
        test_back_to_back();
        mon_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
